// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared state encoding and constants for the multiply/divide unit.
package mult_div_unit_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;
  localparam int MDU_ITER = 32;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
endpackage

// File: rtl/mult_div_unit_addsub33.sv
// mdu_addsub33: 33-bit two's complement add/subtract shared by the multiply and divide paths.
module mdu_addsub33 (
  input  logic [32:0] i_a,
  input  logic [32:0] i_b,
  input  logic        i_sub,
  output logic [32:0] o_sum
);
  assign o_sum = i_sub ? i_a - i_b : i_a + i_b;
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: 32-cycle signed Booth multiply / restoring divide over one shared 33-bit adder.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);
  state_t      r_state, w_next;
  logic [5:0]  r_cnt;
  logic [32:0] r_acc, r_m;
  logic [31:0] r_q, r_result;
  logic        r_qm1, r_neg, r_dbz, r_ovf, r_exc, r_rdy;
  logic        w_start, w_mul, w_busy, w_fin, w_iter, w_sub;
  logic [32:0] w_shl, w_a, w_sum, w_sel;
  logic [31:0] w_abs_a, w_abs_b, w_quo;

  assign w_start = ctrl_MULT | ctrl_DIV;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;

  always_comb begin
    w_next = r_state;
    if (w_start)                 w_next = ctrl_MULT ? ST_MUL : ST_DIV;
    else if (r_state == ST_DONE) w_next = ST_IDLE;
    else if (w_fin)              w_next = ST_DONE;
  end

  always_comb begin
    w_mul  = r_state == ST_MUL;
    w_busy = w_mul | (r_state == ST_DIV);
    w_fin  = w_busy & (r_cnt == 6'(MDU_ITER));
    w_iter = w_busy & ~w_fin;
  end

  // MUL adds/subtracts into acc; DIV trial-subtracts |B| from the left-shifted remainder
  assign w_shl   = {r_acc[31:0], r_q[31]};
  assign w_a     = w_mul ? r_acc : w_shl;
  assign w_sub   = w_mul ? (r_q[0] & ~r_qm1) : 1'b1;
  assign w_sel   = (w_mul & (r_q[0] == r_qm1)) ? r_acc : w_sum;
  assign w_abs_a = data_operandA[31] ? -data_operandA : data_operandA;
  assign w_abs_b = data_operandB[31] ? -data_operandB : data_operandB;
  assign w_quo   = r_neg ? -r_q : r_q;

  mdu_addsub33 u_addsub (
    .i_a  (w_a),
    .i_b  (r_m),
    .i_sub(w_sub),
    .o_sum(w_sum)
  );

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_m      <= '0;
      r_q      <= '0;
      r_qm1    <= 1'b0;
      r_neg    <= 1'b0;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (w_start) begin
        r_cnt <= '0;
        r_acc <= '0;
        r_qm1 <= 1'b0;
        r_m   <= ctrl_MULT ? {data_operandA[31], data_operandA} : {1'b0, w_abs_b};
        r_q   <= ctrl_MULT ? data_operandB : w_abs_a;
        r_neg <= data_operandA[31] ^ data_operandB[31];
        r_dbz <= data_operandB == '0;
        r_ovf <= (data_operandA == INT_MIN) & (data_operandB == '1);
      end else if (w_iter) begin
        r_cnt <= r_cnt + 6'd1;
        r_acc <= w_mul ? {w_sel[32], w_sel[32:1]} : (w_sum[32] ? w_shl : w_sum);
        r_q   <= w_mul ? {w_sel[0], r_q[31:1]} : {r_q[30:0], ~w_sum[32]};
        r_qm1 <= r_q[0];
      end else if (w_fin) begin
        r_rdy    <= 1'b1;
        r_result <= w_mul ? r_q : (r_dbz ? '0 : w_quo);
        r_exc    <= w_mul ? (r_acc[31:0] != {32{r_q[31]}}) : (r_dbz | r_ovf);
      end
    end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
endmodule
